sb_arbiter: RTL

Two-master arbiter for the system bus that feeds the peripheral controllers (LED, switch and similar `*_sb_ctrl` blocks). The core's load/store path (master 0) and a secondary master (master 1, e.g. loader or DMA) share one system-bus port. The arbiter selects one request per transaction, drives the shared bus, and steers read data back to the owning master. Peripherals return read data one cycle after an accepted read request.

---
 rtl/sb_pkg.sv | 15 +
 rtl/sb_rr_pick.sv | 28 ++
 rtl/sb_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared system-bus definitions: bus widths, master indices and arbiter state encoding.
package sb_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  localparam logic SB_M0 = 1'b0;
  localparam logic SB_M1 = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } sb_arb_state_t;

endpackage

// File: rtl/sb_rr_pick.sv
// Two-way request picker. With SB_ARB_RR_EN defined, ties go to the master not granted last;
// otherwise master 0 always wins ties.
module sb_rr_pick
  import sb_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef SB_ARB_RR_EN
  input  logic       last_i,
`endif
  output logic       win_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    win_o   = SB_M0;
    case (req_i)
      2'b10:   win_o = SB_M1;
`ifdef SB_ARB_RR_EN
      2'b11:   win_o = ~last_i;
`else
      2'b11:   win_o = SB_M0;
`endif
      default: win_o = SB_M0;
    endcase
  end

endmodule

// File: rtl/sb_arbiter.sv
// Two-master system-bus arbiter: picks one request, drives the shared bus and returns read data
// to the owner one cycle later. Optional round-robin tie-break via SB_ARB_RR_EN.
module sb_arbiter
  import sb_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wd_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rd_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wd_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rd_o,

  output logic              sb_req_o,
  output logic              sb_we_o,
  output logic [ADDR_W-1:0] sb_addr_o,
  output logic [DATA_W-1:0] sb_wd_o,
  input  logic [DATA_W-1:0] sb_rd_i
);

  sb_arb_state_t state_q, state_d;
  logic          owner_q, owner_d;
  logic          win;
  logic          win_valid;

`ifdef SB_ARB_RR_EN
  logic          last_q, last_d;
`endif

  sb_rr_pick u_pick (
    .req_i   ({m1_req_i, m0_req_i}),
`ifdef SB_ARB_RR_EN
    .last_i  (last_q),
`endif
    .win_o   (win),
    .valid_o (win_valid)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= SB_M0;
`ifdef SB_ARB_RR_EN
      last_q  <= SB_M1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef SB_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
`ifdef SB_ARB_RR_EN
    last_d      = last_q;
`endif
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_rd_o     = '0;
    m1_rd_o     = '0;
    sb_req_o    = 1'b0;
    sb_we_o     = 1'b0;
    sb_addr_o   = '0;
    sb_wd_o     = '0;

    // Outputs are forced quiet for the whole reset window, even with requests pending.
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            sb_req_o  = 1'b1;
            sb_we_o   = (win == SB_M1) ? m1_we_i   : m0_we_i;
            sb_addr_o = (win == SB_M1) ? m1_addr_i : m0_addr_i;
            sb_wd_o   = (win == SB_M1) ? m1_wd_i   : m0_wd_i;
            m0_gnt_o  = (win == SB_M0);
            m1_gnt_o  = (win == SB_M1);
`ifdef SB_ARB_RR_EN
            last_d    = win;
`endif
            if (!sb_we_o) begin
              owner_d = win;
              state_d = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (owner_q == SB_M1) begin
            m1_rvalid_o = 1'b1;
            m1_rd_o     = sb_rd_i;
          end else begin
            m0_rvalid_o = 1'b1;
            m0_rd_o     = sb_rd_i;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
